// File: rtl/adder_seq_master.sv
// AXI4-Lite master: one request becomes write A, write B, read result, then a single response.
// Zero-wait slave gives 7 cycles from request handshake to rsp_valid; rsp_valid holds until rsp_ready.
module adder_seq_master #(
  parameter int                            C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = 32'h43C0_0000,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] OPA_OFFSET         = 32'h0,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] OPB_OFFSET         = 32'h4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] RES_OFFSET         = 32'h8
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_a,
  input  logic [31:0]                   req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_sum,
  output logic                          rsp_err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [31:0]                   M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [31:0]                   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_A_RESP, WR_B, WR_B_RESP, RD_ADDR, RD_DATA, RSP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] sum_q, sum_d;
  logic        err_q, err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        aw_now, w_now;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    sum_d         = sum_q;
    err_d         = err_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    aw_now        = 1'b0;
    w_now         = 1'b0;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    M_AXI_AWADDR  = '0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WDATA   = '0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARADDR  = '0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;

    case (state_q)
      IDLE: begin
        // gated so no handshake is advertised while the bus is held in reset
        req_ready = M_AXI_ARESETN;
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          err_d   = 1'b0;
          state_d = WR_A;
        end
      end
      WR_A, WR_B: begin
        M_AXI_AWADDR  = C_BASE_ADDR + ((state_q == WR_A) ? OPA_OFFSET : OPB_OFFSET);
        M_AXI_WDATA   = (state_q == WR_A) ? a_q : b_q;
        M_AXI_AWVALID = !aw_done_q;
        M_AXI_WVALID  = !w_done_q;
        // each channel retires on its own handshake; the state waits for both
        aw_now = aw_done_q || M_AXI_AWREADY;
        w_now  = w_done_q || M_AXI_WREADY;
        if (aw_now && w_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (state_q == WR_A) ? WR_A_RESP : WR_B_RESP;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      WR_A_RESP, WR_B_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          err_d   = err_q || (M_AXI_BRESP != 2'b00);
          state_d = (state_q == WR_A_RESP) ? WR_B : RD_ADDR;
        end
      end
      RD_ADDR: begin
        M_AXI_ARVALID = 1'b1;
        M_AXI_ARADDR  = C_BASE_ADDR + RES_OFFSET;
        if (M_AXI_ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          sum_d   = M_AXI_RDATA;
          err_d   = err_q || (M_AXI_RRESP != 2'b00);
          state_d = RSP;
        end
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign M_AXI_WSTRB = 4'hF;
  assign rsp_sum     = sum_q;
  assign rsp_err     = err_q;

endmodule

// File: tb/tb_adder_seq_master.sv
// Bench for adder_seq_master: behavioural AXI4-Lite adder slave, request driver, scoreboard monitor.
module tb_adder_seq_master;
  localparam logic [31:0] BASE = 32'h43C0_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_a, req_b, rsp_sum;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  always #5 clk = ~clk;

  adder_seq_master dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct { logic [31:0] sum; logic err; } exp_t;
  exp_t sb[$];
  int   rsp_cnt = 0;
  int   rsp_cyc = 0;
  int   rv_rise = 0;
  logic rv_prev = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && !rv_prev) rv_rise = cyc;
      rv_prev = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: response sum=%0h with nothing expected", rsp_sum);
        end else begin
          e = sb.pop_front();
          check("rsp_sum", rsp_sum, e.sum);
          check("rsp_err", rsp_err, e.err);
        end
        rsp_cnt++;
        rsp_cyc = cyc;
      end
    end
  end

  // ---------------- AXI4-Lite adder slave ----------------
  int          aw_delay = 0;
  logic [1:0]  bresp_a = 2'b00, bresp_b = 2'b00;
  logic [31:0] mem_a, mem_b, pa, pd, s_awaddr, s_wdata, s_araddr, aw_prev, w_prev;
  logic        aw_got, w_got, aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_pend, w_pend;
  int          aw_cnt;
  logic [31:0] wl_addr[$], wl_data[$], ar_log[$];

  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
    mem_a = 0; mem_b = 0; aw_got = 0; w_got = 0; aw_cnt = 0; aw_pend = 0; w_pend = 0;
    forever begin
      @(negedge clk);
      aw_hs = AWVALID && AWREADY; w_hs = WVALID && WREADY; b_hs = BVALID && BREADY;
      ar_hs = ARVALID && ARREADY; r_hs = RVALID && RREADY;
      s_awaddr = AWADDR; s_wdata = WDATA; s_araddr = ARADDR;
      // a VALID left waiting must stay up with unchanged payload
      if (aw_pend && rst_n) check("aw_stable", {AWVALID, AWADDR}, {1'b1, aw_prev});
      if (w_pend && rst_n)  check("w_stable", {WVALID, WDATA}, {1'b1, w_prev});
      aw_pend = AWVALID && !AWREADY; aw_prev = AWADDR;
      w_pend  = WVALID && !WREADY;   w_prev  = WDATA;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        aw_got = 0; w_got = 0; aw_cnt = 0; aw_pend = 0; w_pend = 0;
        continue;
      end
      if (aw_hs) begin aw_got = 1; pa = s_awaddr; end
      if (w_hs) begin w_got = 1; pd = s_wdata; aw_cnt = aw_delay; end
      else if (aw_cnt > 0) aw_cnt--;
      if (b_hs) BVALID = 0;
      if (aw_got && w_got) begin
        wl_addr.push_back(pa); wl_data.push_back(pd);
        if (pa == BASE) mem_a = pd;
        if (pa == BASE + 32'h4) mem_b = pd;
        BVALID = 1;
        BRESP  = (pa == BASE + 32'h4) ? bresp_b : bresp_a;
        aw_got = 0; w_got = 0;
      end
      AWREADY = !aw_got && ((aw_delay == 0) || (w_got && aw_cnt == 0));
      WREADY  = !w_got;
      if (r_hs) RVALID = 0;
      if (ar_hs) begin
        ar_log.push_back(s_araddr);
        RVALID = 1; RDATA = mem_a + mem_b; RRESP = 2'b00;
      end
      ARREADY = 1;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                       input logic e, output int hs);
    exp_t x;
    x.sum = s; x.err = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    req_a = a; req_b = b; req_valid = 1; hs = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin hs = cyc; break; end
    end
    if (hs < 0) timeout("req_accept");
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask

  task automatic wait_rsp(input int n0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_cnt > n0) return;
    end
    timeout("rsp_wait");
  endtask

  task automatic check_bus(input logic [31:0] a, input logic [31:0] b);
    check("wr_count", wl_addr.size(), 2);
    if (wl_addr.size() == 2) begin
      check("wr_a_addr", wl_addr[0], BASE);
      check("wr_a_data", wl_data[0], a);
      check("wr_b_addr", wl_addr[1], BASE + 32'h4);
      check("wr_b_data", wl_data[1], b);
    end
    check("rd_count", ar_log.size(), 1);
    if (ar_log.size() == 1) check("rd_addr", ar_log[0], BASE + 32'h8);
    wl_addr.delete(); wl_data.delete(); ar_log.delete();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ctl"}, {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_err, req_ready}, 8'h00);
    check({tag, "_sum"}, rsp_sum, 32'h0);
    check({tag, "_awaddr"}, AWADDR, 32'h0);
    check({tag, "_araddr"}, ARADDR, 32'h0);
    check({tag, "_wdata"}, WDATA, 32'h0);
    check({tag, "_wstrb"}, WSTRB, 4'hF);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int hs, hs2, n0;
    bit seen;
    rst_n = 0; req_valid = 0; req_a = 0; req_b = 0; rsp_ready = 1;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1;
    repeat (2) @(negedge clk);
    check("idle_req_ready", req_ready, 1'b1);

    // zero-wait: 1 + 2, latency
    n0 = rsp_cnt;
    issue(32'd1, 32'd2, 32'd3, 1'b0, hs);
    wait_rsp(n0);
    check("latency", rv_rise - hs, 7);
    check_bus(32'd1, 32'd2);

    // AWREADY late by 3 cycles after WREADY; sum wraps
    aw_delay = 3;
    n0 = rsp_cnt;
    issue(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, hs);
    wait_rsp(n0);
    check_bus(32'hFFFF_FFFF, 32'd1);
    aw_delay = 0;

    // SLVERR on operand-B write still reads the result
    bresp_b = 2'b10;
    n0 = rsp_cnt;
    issue(32'd5, 32'd7, 32'd12, 1'b1, hs);
    wait_rsp(n0);
    check_bus(32'd5, 32'd7);
    bresp_b = 2'b00;

    // response held off 10 cycles, second request waiting behind it
    @(posedge clk);
    #1;
    rsp_ready = 0;
    issue(32'd10, 32'd20, 32'd30, 1'b0, hs);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; break; end
    end
    if (!seen) timeout("hold_rsp_valid");
    check_bus(32'd10, 32'd20);
    begin
      exp_t x;
      x.sum = 32'd300; x.err = 1'b0;
      sb.push_back(x);
    end
    req_a = 32'd100; req_b = 32'd200; req_valid = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_state", {rsp_valid, rsp_sum, req_ready}, {1'b1, 32'd30, 1'b0});
    end
    @(posedge clk);
    #1;
    rsp_ready = 1;
    hs2 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) begin hs2 = cyc; break; end
    end
    if (hs2 < 0) timeout("b2b_accept");
    else check("b2b_accept", hs2 - rsp_cyc, 1);
    @(posedge clk);
    #1;
    req_valid = 0;
    n0 = rsp_cnt;
    wait_rsp(n0);
    check_bus(32'd100, 32'd200);

    // reset pulsed while waiting for read data
    issue(32'd3, 32'd4, 32'd7, 1'b0, hs);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (RREADY) begin seen = 1; break; end
    end
    if (!seen) timeout("reach_rd_data");
    rst_n = 0;
    #1;
    check_reset_outs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1;
    sb.delete();
    wl_addr.delete(); wl_data.delete(); ar_log.delete();
    n0 = rsp_cnt;
    issue(32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, hs);
    wait_rsp(n0);
    check_bus(32'h1234_5678, 32'h1111_1111);
    check("sb_drained", sb.size(), 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
